// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched: two-requester front end for a fixed-latency FP add/sub core.
// Arbitrates between requesters, issues to the core, and tracks each issued
// operation with a tag pipeline so the result can be routed back in order.
module fp_addsub_sched #(
   parameter int WIDTH    = 32,
   parameter int CORE_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_op,
   input  logic             hold,
   output logic             core_valid,
   output logic [WIDTH-1:0] core_a,
   output logic [WIDTH-1:0] core_b,
   output logic             core_op,
   input  logic [WIDTH-1:0] core_result,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       inflight_cnt,
   output logic             busy
);

   // 1 = requester 1 was granted most recently
   logic                last_grant;
   logic                accept;
   logic                core_id;
   logic [CORE_LAT-1:0] vld_pipe;
   logic [CORE_LAT-1:0] id_pipe;
   logic                rsp_any;

   // Round-robin grant; both readies are forced low under hold or reset
   always_comb begin
      req0_ready = !rst && !hold && req0_valid && (!req1_valid || last_grant);
      req1_ready = !rst && !hold && req1_valid && (!req0_valid || !last_grant);
      accept     = req0_ready || req1_ready;
   end

   assign rsp_any = rsp0_valid || rsp1_valid;
   assign busy    = (inflight_cnt != 4'd0);

   // Grant pointer moves only when a request is actually taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         last_grant <= 1'b1;
      else if (accept) last_grant <= req1_ready;
   end

   // Issue register: operands held between issues
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_valid <= 1'b0;
         core_a     <= '0;
         core_b     <= '0;
         core_op    <= 1'b0;
         core_id    <= 1'b0;
      end else begin
         core_valid <= accept;
         if (accept) begin
            core_a  <= req1_ready ? req1_a  : req0_a;
            core_b  <= req1_ready ? req1_b  : req0_b;
            core_op <= req1_ready ? req1_op : req0_op;
            core_id <= req1_ready;
         end
      end
   end

   // Tag pipeline tracks the core; its last stage lines up with core_result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe[0] <= core_valid;
         id_pipe[0]  <= core_id;
         for (int i = 1; i < CORE_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            id_pipe[i]  <= id_pipe[i-1];
         end
      end
   end

   // Capture the core result and strobe the owning requester
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_result <= '0;
      end else begin
         rsp0_valid <= vld_pipe[CORE_LAT-1] && !id_pipe[CORE_LAT-1];
         rsp1_valid <= vld_pipe[CORE_LAT-1] &&  id_pipe[CORE_LAT-1];
         if (vld_pipe[CORE_LAT-1]) rsp_result <= core_result;
      end
   end

   // Outstanding count: accept adds, response retires, both together cancel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) inflight_cnt <= 4'd0;
      else begin
         case ({accept, rsp_any})
            2'b10:   inflight_cnt <= inflight_cnt + 4'd1;
            2'b01:   inflight_cnt <= inflight_cnt - 4'd1;
            default: inflight_cnt <= inflight_cnt;
         endcase
      end
   end

endmodule
